regbank_reader: RTL and testbench

Read side of the register bank: a 2^select_bits-entry storage array with one write port and two registered read ports (A, B). It sits between instruction decode and the execute stage; decode presents two source register indices with a request strobe, and one cycle later the block returns both operands with a valid flag. It also provides register-0-reads-zero, same-cycle write-to-read forwarding and a pipeline hold.

---
 rtl/regbank_reader_pkg.sv | 14 +
 rtl/regbank_read_mux.sv | 36 +++
 rtl/regbank_reader.sv | 92 +++++++++
 tb/tb_regbank_reader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regbank_reader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regbank_reader_pkg : shared constants for the register bank read side
// Revision 1.0
// ---------------------------------------------------------------------------
package regbank_reader_pkg;

  localparam int REG_ZERO    = 0;
  localparam int SELECT_BITS = 5;
  localparam int DATA_BITS   = 32;
  localparam int NUM_REGS    = 1 << SELECT_BITS;

endpackage
`default_nettype wire

// File: rtl/regbank_read_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regbank_read_mux : N:1 entry select with zero-index and write forwarding
// Revision 1.0
// ---------------------------------------------------------------------------
module regbank_read_mux
  import regbank_reader_pkg::*;
#(
  parameter int SELECT_BITS = regbank_reader_pkg::SELECT_BITS,
  parameter int DATA_BITS   = regbank_reader_pkg::DATA_BITS,
  parameter int NUM_ENTRIES = 1 << SELECT_BITS
) (
  input  logic [DATA_BITS-1:0]   regs [NUM_ENTRIES-1:1],
  input  logic [SELECT_BITS-1:0] rd_addr,
  input  logic                   wr_en,
  input  logic [SELECT_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0]   wr_data,
  output logic [DATA_BITS-1:0]   rd_data
);

  localparam logic [SELECT_BITS-1:0] C_ZERO_IDX = SELECT_BITS'(REG_ZERO);

  // Zero index wins over forwarding, so a discarded r0 write never leaks out.
  always_comb begin
    rd_data = '0;
    if (rd_addr == C_ZERO_IDX) begin
      rd_data = '0;
    end else if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = regs[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/regbank_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regbank_reader : register bank with one write port, two registered reads
// Revision 1.0
// ---------------------------------------------------------------------------
module regbank_reader
  import regbank_reader_pkg::*;
#(
  parameter int SELECT_BITS = regbank_reader_pkg::SELECT_BITS,
  parameter int DATA_BITS   = regbank_reader_pkg::DATA_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [SELECT_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic                   rd_req,
  input  logic [SELECT_BITS-1:0] rd_addr_a,
  input  logic [SELECT_BITS-1:0] rd_addr_b,
  input  logic                   hold,
  output logic [DATA_BITS-1:0]   rd_data_a,
  output logic [DATA_BITS-1:0]   rd_data_b,
  output logic                   rd_valid
);

  localparam int NUM_ENTRIES = 1 << SELECT_BITS;

  logic [DATA_BITS-1:0] r_regs [NUM_ENTRIES-1:1];
  logic [DATA_BITS-1:0] w_mux_a;
  logic [DATA_BITS-1:0] w_mux_b;
  logic [DATA_BITS-1:0] r_data_a;
  logic [DATA_BITS-1:0] r_data_b;
  logic                 r_valid;

  // Entry 0 has no storage; the decode below can never match index 0.
  for (genvar i = 1; i < NUM_ENTRIES; i++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_regs[i] <= '0;
      end else if (wr_en && (wr_addr == SELECT_BITS'(i))) begin
        r_regs[i] <= wr_data;
      end
    end
  end

  regbank_read_mux #(
    .SELECT_BITS (SELECT_BITS),
    .DATA_BITS   (DATA_BITS),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_mux_a (
    .regs    (r_regs),
    .rd_addr (rd_addr_a),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (w_mux_a)
  );

  regbank_read_mux #(
    .SELECT_BITS (SELECT_BITS),
    .DATA_BITS   (DATA_BITS),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_mux_b (
    .regs    (r_regs),
    .rd_addr (rd_addr_b),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_data (w_mux_b)
  );

  // Data is only captured on accept, so a hold never refreshes stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_a <= '0;
      r_data_b <= '0;
      r_valid  <= 1'b0;
    end else if (!hold) begin
      r_valid <= rd_req;
      if (rd_req) begin
        r_data_a <= w_mux_a;
        r_data_b <= w_mux_b;
      end
    end
  end

  assign rd_data_a = r_data_a;
  assign rd_data_b = r_data_b;
  assign rd_valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_regbank_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regbank_reader : directed self-checking bench for regbank_reader
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_regbank_reader;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        hold;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        rd_valid;

  int n_tests = 0;
  int n_fails = 0;

  regbank_reader u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .hold      (hold),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .rd_valid  (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic set_rd(input logic req, input logic [4:0] a, input logic [4:0] b);
    rd_req    = req;
    rd_addr_a = a;
    rd_addr_b = b;
  endtask

  initial begin
    rst_n = 1'b1;
    hold  = 1'b0;
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b0, 5'd0, 5'd0);

    // Preload r3 and capture it so reset has something to clear.
    step();
    set_wr(1'b1, 5'd3, 32'h0000_0055);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 5'd3, 5'd3);
    step();
    check("preload_a", rd_data_a, 32'h0000_0055);
    check("preload_valid", {31'b0, rd_valid}, 32'h1);

    // Asynchronous reset mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_a", rd_data_a, 32'h0);
    check("rst_async_b", rd_data_b, 32'h0);
    check("rst_async_valid", {31'b0, rd_valid}, 32'h0);

    // Write attempted while reset is asserted must be dropped.
    set_rd(1'b1, 5'd3, 5'd7);
    set_wr(1'b1, 5'd7, 32'h0000_0077);
    step();
    check("rst_held_valid", {31'b0, rd_valid}, 32'h0);
    rst_n = 1'b1;
    set_wr(1'b0, 5'd0, 32'h0);
    step();
    check("post_rst_a", rd_data_a, 32'h0);
    check("post_rst_b", rd_data_b, 32'h0);
    check("post_rst_valid", {31'b0, rd_valid}, 32'h1);

    // Write r5, then read it on both ports.
    set_rd(1'b0, 5'd0, 5'd0);
    set_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
    step();
    check("idle_valid", {31'b0, rd_valid}, 32'h0);
    check("idle_keep_a", rd_data_a, 32'h0);
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 5'd5, 5'd5);
    step();
    check("wr_rd_a", rd_data_a, 32'hDEAD_BEEF);
    check("wr_rd_b", rd_data_b, 32'hDEAD_BEEF);
    check("wr_rd_valid", {31'b0, rd_valid}, 32'h1);

    // Forwarding on A while B reads a stored entry.
    set_rd(1'b0, 5'd0, 5'd0);
    set_wr(1'b1, 5'd8, 32'h0000_0011);
    step();
    set_wr(1'b1, 5'd9, 32'h1234_5678);
    set_rd(1'b1, 5'd9, 5'd8);
    step();
    check("fwd_a", rd_data_a, 32'h1234_5678);
    check("fwd_b", rd_data_b, 32'h0000_0011);

    // Forwarding on both ports with equal addresses.
    set_wr(1'b1, 5'd12, 32'hCAFE_0012);
    set_rd(1'b1, 5'd12, 5'd12);
    step();
    check("fwd_both_a", rd_data_a, 32'hCAFE_0012);
    check("fwd_both_b", rd_data_b, 32'hCAFE_0012);

    // Register 0 ignores writes, including a same-edge one.
    set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(1'b1, 5'd0, 5'd9);
    step();
    check("r0_fwd_a", rd_data_a, 32'h0);
    check("r0_other_b", rd_data_b, 32'h1234_5678);
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 5'd0, 5'd0);
    step();
    check("r0_later_a", rd_data_a, 32'h0);
    check("r0_later_b", rd_data_b, 32'h0);

    // Hold: capture r4=0xA, then stall while r4 is rewritten.
    set_rd(1'b0, 5'd0, 5'd0);
    set_wr(1'b1, 5'd4, 32'h0000_000A);
    step();
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b1, 5'd4, 5'd4);
    step();
    check("hold_cap_a", rd_data_a, 32'h0000_000A);
    hold = 1'b1;
    set_wr(1'b1, 5'd4, 32'h0000_000B);
    for (int i = 0; i < 3; i++) begin
      set_rd(i[0] ? 1'b0 : 1'b1, 5'd4, 5'd4);
      step();
      check($sformatf("hold%0d_a", i), rd_data_a, 32'h0000_000A);
      check($sformatf("hold%0d_b", i), rd_data_b, 32'h0000_000A);
      check($sformatf("hold%0d_valid", i), {31'b0, rd_valid}, 32'h1);
    end
    hold = 1'b0;
    set_wr(1'b0, 5'd0, 32'h0);
    set_rd(1'b0, 5'd4, 5'd4);
    step();
    check("unhold_valid", {31'b0, rd_valid}, 32'h0);
    check("unhold_a", rd_data_a, 32'h0000_000A);
    set_rd(1'b1, 5'd4, 5'd4);
    step();
    check("hold_write_kept", rd_data_a, 32'h0000_000B);

    // Back-to-back reads of r1..r4 holding 1..4.
    set_rd(1'b0, 5'd0, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      set_wr(1'b1, 5'(i), 32'(i));
      step();
    end
    set_wr(1'b0, 5'd0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      set_rd(1'b1, 5'(i), 5'(5 - i));
      step();
      check($sformatf("b2b%0d_a", i), rd_data_a, 32'(i));
      check($sformatf("b2b%0d_b", i), rd_data_b, 32'(5 - i));
      check($sformatf("b2b%0d_valid", i), {31'b0, rd_valid}, 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
